// File: rtl/boss_dmg_arbiter.sv
// Serialises melee / projectile / remote-player hits into rate-limited boss HP
// decrements under round-robin arbitration; sole owner of boss_hp.
module boss_dmg_arbiter #(
    parameter int MAX_HP         = 100,
    parameter int MELEE_DMG      = 3,
    parameter int PROJ_DMG       = 1,
    parameter int P2_DMG         = 2,
    parameter int PEND_MAX       = 7,
    parameter int COOLDOWN_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       game_active,
    input  logic       frame_tick,
    input  logic       melee_hit,
    input  logic       projectile_hit,
    input  logic       p2_hit,
    input  logic       p2_valid,
    output logic [6:0] boss_hp,
    output logic       boss_alive,
    output logic       dmg_apply,
    output logic [1:0] dmg_src,
    output logic       hit_flash,
    output logic [1:0] dbg_state,
    output logic [1:0] dbg_ptr
);

    // Handshake: requests are level inputs turned into single-cycle events by
    // rising-edge detection; there is no back-pressure, excess hits saturate.

    typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, COOLDOWN = 2'd2, DEAD = 2'd3} state_t;

    localparam logic [6:0] HP_INIT   = 7'(MAX_HP);
    localparam logic [2:0] PEND_SAT  = 3'(PEND_MAX);
    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_TICKS - 1);

    state_t      state, state_nx;
    logic [2:0]  req_q;
    logic [2:0]  req_in;
    logic [2:0]  edge_det;
    logic        accept;
    logic [2:0]  pend [3];
    logic [2:0]  pend_nz;
    logic        grant_vld;
    logic [1:0]  grant_src;
    logic [1:0]  rr_cand;
    logic [1:0]  src_q;
    logic [1:0]  ptr;
    logic [7:0]  cool_cnt;
    logic [7:0]  dmg8;
    logic [8:0]  diff;
    logic [6:0]  hp_new;

    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    assign req_in   = {p2_hit, projectile_hit, melee_hit};
    assign edge_det = req_in & ~req_q & {p2_valid, 2'b11};
    assign accept   = game_active && (state != DEAD) && !game_start;

    always_comb begin
        for (int i = 0; i < 3; i++) pend_nz[i] = |pend[i];
    end

    // Scan from the furthest candidate back to ptr so the nearest one wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = 2'd0;
        rr_cand   = 2'd0;
        if (state == IDLE && game_active) begin
            for (int i = 2; i >= 0; i--) begin
                rr_cand = rr_idx(ptr, 2'(i));
                if (pend_nz[rr_cand]) begin
                    grant_vld = 1'b1;
                    grant_src = rr_cand;
                end
            end
        end
    end

    // 8-bit borrow check: a borrow means the hit overkills, clamp to zero.
    always_comb begin
        case (src_q)
            2'd0:    dmg8 = 8'(MELEE_DMG);
            2'd1:    dmg8 = 8'(PROJ_DMG);
            default: dmg8 = 8'(P2_DMG);
        endcase
        diff   = {2'b00, boss_hp} - {1'b0, dmg8};
        hp_new = diff[8] ? 7'd0 : 7'(diff);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (game_start) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:     if (grant_vld) state_nx = APPLY;
                APPLY:    state_nx = (hp_new == 7'd0) ? DEAD : COOLDOWN;
                COOLDOWN: if (frame_tick && cool_cnt == COOL_LAST) state_nx = IDLE;
                default:  state_nx = DEAD;
            endcase
        end
    end

    always_comb begin
        hit_flash = (state == COOLDOWN);
        dbg_state = state;
        dbg_ptr   = ptr;
    end

    assign boss_alive = |boss_hp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q     <= 3'd0;
            for (int i = 0; i < 3; i++) pend[i] <= 3'd0;
            ptr       <= 2'd0;
            src_q     <= 2'd0;
            cool_cnt  <= 8'd0;
            boss_hp   <= HP_INIT;
            dmg_apply <= 1'b0;
            dmg_src   <= 2'd0;
        end else begin
            req_q <= req_in;
            if (game_start) begin
                for (int i = 0; i < 3; i++) pend[i] <= 3'd0;
                ptr       <= 2'd0;
                src_q     <= 2'd0;
                cool_cnt  <= 8'd0;
                boss_hp   <= HP_INIT;
                dmg_apply <= 1'b0;
            end else begin
                dmg_apply <= 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (state == DEAD || !game_active) begin
                        pend[i] <= 3'd0;
                    end else if (edge_det[i] && accept
                                 && !(grant_vld && grant_src == 2'(i))) begin
                        if (pend[i] != PEND_SAT) pend[i] <= pend[i] + 3'd1;
                    end else if (!(edge_det[i] && accept)
                                 && grant_vld && grant_src == 2'(i)) begin
                        pend[i] <= pend[i] - 3'd1;
                    end
                end
                if (grant_vld) begin
                    ptr   <= rr_idx(grant_src, 2'd1);
                    src_q <= grant_src;
                end
                if (state == APPLY) begin
                    boss_hp   <= hp_new;
                    dmg_src   <= src_q;
                    dmg_apply <= 1'b1;
                    cool_cnt  <= 8'd0;
                end else if (state == COOLDOWN && frame_tick) begin
                    cool_cnt <= cool_cnt + 8'd1;
                end
            end
        end
    end

endmodule
